// File: rtl/core_ex.sv
// Execute stage of the xRV32I core: single-cycle ALU plus a bit-serial shifter.
// Produces a registered write-back result for the EX/MEM stage.
module core_ex #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eval_en_in,
    input  logic [DATA_W-1:0] opnum1_in,
    input  logic [DATA_W-1:0] opnum2_in,
    input  logic [FUNC_W-1:0] func_in,
    input  logic              reg_we_in,
    input  logic [4:0]        reg_write_addr_in,
    input  logic              flush_in,
    output logic              stall_out,
    output logic              valid_out,
    output logic              reg_we_out,
    output logic [4:0]        reg_write_addr_out,
    output logic [DATA_W-1:0] reg_write_data_out,
    output logic              dbg_state_out
);

    localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] F_SLL  = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] F_SLT  = FUNC_W'(3);
    localparam logic [FUNC_W-1:0] F_SLTU = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] F_XOR  = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] F_SRL  = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] F_SRA  = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] F_OR   = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] F_AND  = FUNC_W'(9);

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_acc;
    logic [4:0]        r_cnt;
    logic [FUNC_W-1:0] r_func;
    logic              r_we;
    logic [4:0]        r_addr;
    logic              r_valid;
    logic              r_we_out;
    logic [4:0]        r_wa;
    logic [DATA_W-1:0] r_wd;

    logic              w_is_shift_func;
    logic              w_start_shift;
    logic              w_shift_last;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_step;

    assign w_is_shift_func = (func_in == F_SLL) || (func_in == F_SRL) || (func_in == F_SRA);
    assign w_start_shift   = (r_state == S_IDLE) && eval_en_in && w_is_shift_func &&
                             (opnum2_in[4:0] != 5'd0) && !flush_in;
    assign w_shift_last    = (r_state == S_SHIFT) && (r_cnt == 5'd1);

    // Handshake: stall_out high means ID/EX must hold its contents; valid_out high
    // means the write-back fields carry a fresh result for exactly that cycle.
    assign stall_out = rst && (w_start_shift ||
                       ((r_state == S_SHIFT) && !w_shift_last && !flush_in));

    always_comb begin
        w_alu = opnum1_in + opnum2_in;
        case (func_in)
            F_SUB:               w_alu = opnum1_in - opnum2_in;
            F_SLL, F_SRL, F_SRA: w_alu = opnum1_in;  // only shift-by-zero reaches here
            F_SLT:               w_alu = {{(DATA_W-1){1'b0}}, $signed(opnum1_in) < $signed(opnum2_in)};
            F_SLTU:              w_alu = {{(DATA_W-1){1'b0}}, opnum1_in < opnum2_in};
            F_XOR:               w_alu = opnum1_in ^ opnum2_in;
            F_OR:                w_alu = opnum1_in | opnum2_in;
            F_AND:               w_alu = opnum1_in & opnum2_in;
            default:             w_alu = opnum1_in + opnum2_in;
        endcase
    end

    always_comb begin
        w_step = r_acc >> 1;
        case (r_func)
            F_SLL:   w_step = r_acc << 1;
            F_SRA:   w_step = {r_acc[DATA_W-1], r_acc[DATA_W-1:1]};
            default: w_step = r_acc >> 1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_in) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_shift) w_state_next = S_SHIFT;
                S_SHIFT: if (w_shift_last) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_func   <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_we_out <= 1'b0;
            r_wa     <= '0;
            r_wd     <= '0;
        end else begin
            r_valid  <= 1'b0;
            r_we_out <= 1'b0;
            if (!flush_in) begin
                if (r_state == S_IDLE) begin
                    if (w_start_shift) begin
                        r_acc  <= opnum1_in;
                        r_cnt  <= opnum2_in[4:0];
                        r_func <= func_in;
                        r_we   <= reg_we_in;
                        r_addr <= reg_write_addr_in;
                    end else if (eval_en_in) begin
                        r_valid  <= 1'b1;
                        r_we_out <= reg_we_in && (reg_write_addr_in != 5'd0);
                        r_wa     <= reg_write_addr_in;
                        r_wd     <= w_alu;
                    end
                end else begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - 5'd1;
                    if (w_shift_last) begin
                        r_valid  <= 1'b1;
                        r_we_out <= r_we && (r_addr != 5'd0);
                        r_wa     <= r_addr;
                        r_wd     <= w_step;
                    end
                end
            end
        end
    end

    assign valid_out          = r_valid;
    assign reg_we_out         = r_we_out;
    assign reg_write_addr_out = r_wa;
    assign reg_write_data_out = r_wd;
    assign dbg_state_out      = r_state;

endmodule

// File: tb/tb_core_ex.sv
// Directed bench for core_ex: hand-computed ALU/shift results, stall counts,
// flush and asynchronous reset behaviour.
module tb_core_ex;

    logic        clk;
    logic        rst;
    logic        eval_en_in;
    logic [31:0] opnum1_in;
    logic [31:0] opnum2_in;
    logic [3:0]  func_in;
    logic        reg_we_in;
    logic [4:0]  reg_write_addr_in;
    logic        flush_in;
    logic        stall_out;
    logic        valid_out;
    logic        reg_we_out;
    logic [4:0]  reg_write_addr_out;
    logic [31:0] reg_write_data_out;
    logic        dbg_state_out;

    int checks;
    int failures;

    core_ex #(.DATA_W(32), .FUNC_W(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .eval_en_in         (eval_en_in),
        .opnum1_in          (opnum1_in),
        .opnum2_in          (opnum2_in),
        .func_in            (func_in),
        .reg_we_in          (reg_we_in),
        .reg_write_addr_in  (reg_write_addr_in),
        .flush_in           (flush_in),
        .stall_out          (stall_out),
        .valid_out          (valid_out),
        .reg_we_out         (reg_we_out),
        .reg_write_addr_out (reg_write_addr_out),
        .reg_write_data_out (reg_write_data_out),
        .dbg_state_out      (dbg_state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Presents one op, holds it while stalled, then checks the result cycle.
    // Leaves the op on the inputs; the caller presents the next op right away.
    task automatic exec_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic we, input logic [4:0] rd,
                           input logic [31:0] exp_d, input logic exp_we, input int exp_stalls);
        int stalls;
        int guard;
        eval_en_in        = 1'b1;
        func_in           = f;
        opnum1_in         = a;
        opnum2_in         = b;
        reg_we_in         = we;
        reg_write_addr_in = rd;
        #1;
        stalls = 0;
        guard  = 0;
        while (stall_out && guard < 40) begin
            stalls++;
            guard++;
            @(posedge clk);
            #2;
        end
        check_eq({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
        check_eq({tag, "_data"}, reg_write_data_out, exp_d);
        check_eq({tag, "_we"}, {31'd0, reg_we_out}, {31'd0, exp_we});
        check_eq({tag, "_addr"}, {27'd0, reg_write_addr_out}, {27'd0, rd});
    endtask

    task automatic idle_cycle(input string tag, input logic [4:0] hold_a, input logic [31:0] hold_d);
        eval_en_in = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        check_eq({tag, "_we"}, {31'd0, reg_we_out}, 32'd0);
        check_eq({tag, "_hold_addr"}, {27'd0, reg_write_addr_out}, {27'd0, hold_a});
        check_eq({tag, "_hold_data"}, reg_write_data_out, hold_d);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b0;
        eval_en_in        = 1'b0;
        opnum1_in         = '0;
        opnum2_in         = '0;
        func_in           = '0;
        reg_we_in         = 1'b0;
        reg_write_addr_in = '0;
        flush_in          = 1'b0;

        #22;
        check_eq("rst_stall", {31'd0, stall_out}, 32'd0);
        check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("rst_we", {31'd0, reg_we_out}, 32'd0);
        check_eq("rst_addr", {27'd0, reg_write_addr_out}, 32'd0);
        check_eq("rst_data", reg_write_data_out, 32'd0);
        check_eq("rst_state", {31'd0, dbg_state_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        exec_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 5'd5, 32'h0000_0001, 1'b1, 0);
        exec_op("sra3", 4'd7, 32'h8000_0000, 32'd3, 1'b1, 5'd6, 32'hF000_0000, 1'b1, 3);
        exec_op("add_after_sra", 4'd0, 32'd1, 32'd1, 1'b1, 5'd7, 32'd2, 1'b1, 0);
        exec_op("sll31", 4'd2, 32'd1, 32'd31, 1'b1, 5'd8, 32'h8000_0000, 1'b1, 31);
        exec_op("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd9, 32'd1, 1'b1, 0);
        exec_op("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd10, 32'd0, 1'b1, 0);
        exec_op("sub_rd0", 4'd1, 32'd5, 32'd7, 1'b1, 5'd0, 32'hFFFF_FFFE, 1'b0, 0);
        exec_op("xor", 4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 5'd11, 32'hFF00_FF00, 1'b1, 0);
        exec_op("or", 4'd8, 32'h1234_0000, 32'h0000_5678, 1'b1, 5'd12, 32'h1234_5678, 1'b1, 0);
        exec_op("and", 4'd9, 32'hFFFF_00FF, 32'h0F0F_0F0F, 1'b1, 5'd13, 32'h0F0F_000F, 1'b1, 0);
        exec_op("srl4", 4'd6, 32'hF000_0000, 32'd4, 1'b1, 5'd14, 32'h0F00_0000, 1'b1, 4);
        exec_op("sra1_pos", 4'd7, 32'h4000_0000, 32'd1, 1'b1, 5'd15, 32'h2000_0000, 1'b1, 1);
        exec_op("sll0", 4'd2, 32'hDEAD_BEEF, 32'h0000_0020, 1'b1, 5'd16, 32'hDEAD_BEEF, 1'b1, 0);
        exec_op("func12_add", 4'd12, 32'd10, 32'd20, 1'b1, 5'd17, 32'd30, 1'b1, 0);
        exec_op("add_we0", 4'd0, 32'd100, 32'd23, 1'b0, 5'd3, 32'd123, 1'b0, 0);
        idle_cycle("idle1", 5'd3, 32'd123);
        idle_cycle("idle2", 5'd3, 32'd123);

        // SRL by 10, flush in the fourth cycle of the shift
        eval_en_in        = 1'b1;
        func_in           = 4'd6;
        opnum1_in         = 32'hFFFF_0000;
        opnum2_in         = 32'd10;
        reg_we_in         = 1'b1;
        reg_write_addr_in = 5'd11;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("flush_pre_stall", {31'd0, stall_out}, 32'd1);
            @(posedge clk);
            #2;
        end
        flush_in = 1'b1;
        #1;
        check_eq("flush_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        #1;
        flush_in   = 1'b0;
        eval_en_in = 1'b0;
        #1;
        check_eq("flush_valid", {31'd0, valid_out}, 32'd0);
        check_eq("flush_we", {31'd0, reg_we_out}, 32'd0);
        check_eq("flush_state", {31'd0, dbg_state_out}, 32'd0);
        check_eq("flush_post_stall", {31'd0, stall_out}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check_eq("flush_no_result", {31'd0, valid_out}, 32'd0);
        end

        // Asynchronous reset in the middle of an SRL by 20
        eval_en_in        = 1'b1;
        func_in           = 4'd6;
        opnum1_in         = 32'hABCD_1234;
        opnum2_in         = 32'd20;
        reg_we_in         = 1'b1;
        reg_write_addr_in = 5'd20;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_shift_state", {31'd0, dbg_state_out}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("arst_stall", {31'd0, stall_out}, 32'd0);
        check_eq("arst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("arst_we", {31'd0, reg_we_out}, 32'd0);
        check_eq("arst_addr", {27'd0, reg_write_addr_out}, 32'd0);
        check_eq("arst_data", reg_write_data_out, 32'd0);
        check_eq("arst_state", {31'd0, dbg_state_out}, 32'd0);
        eval_en_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exec_op("add_after_rst", 4'd0, 32'd3, 32'd4, 1'b1, 5'd7, 32'd7, 1'b1, 0);
        idle_cycle("final_idle", 5'd7, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_ex.md
# core_ex

Execute stage of the xRV32I core: the consuming end of the ID/EX pipeline register. It takes the registered ALU operands, function code and write-back target, computes single-cycle ALU results and performs shifts iteratively, one bit per cycle. During a shift it raises `stall_out` so the ID/EX register holds its contents. It presents a registered write-back result (`valid_out`, `reg_we_out`, address, data) to the EX/MEM stage.

## Interface
Parameters:
- `DATA_W`, 32: operand and result width.
- `FUNC_W`, 4: ALU function code width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `eval_en_in`  in  1  ALU operation valid from ID/EX.
- `opnum1_in`  in  32  operand 1.
- `opnum2_in`  in  32  operand 2; shifts use `[4:0]` only.
- `func_in`  in  4  function code: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9; codes 10–15 behave as ADD.
- `reg_we_in`  in  1  write-back requested.
- `reg_write_addr_in`  in  5  destination register.
- `flush_in`  in  1  synchronous kill of the current or in-flight operation.
- `stall_out`  out  1  combinational; when high, ID/EX must hold.
- `valid_out`  out  1  registered; result present this cycle.
- `reg_we_out`  out  1  registered write enable.
- `reg_write_addr_out`  out  5  registered destination.
- `reg_write_data_out`  out  32  registered result.

## Operation
- States: IDLE and SHIFT. Internal registers: accumulator `acc` (32 bits), count `cnt` (5 bits), latched func, latched write-back enable, latched destination address.
- A shift start (`start_shift`) is: IDLE, `eval_en_in` = 1, func ∈ {SLL, SRL, SRA}, `opnum2_in[4:0]` ≠ 0, and `flush_in` = 0.
- IDLE, `eval_en_in` = 1, not `start_shift`: compute combinationally and register the result. `valid_out` = 1 on the next cycle. A shift by 0 takes this path and returns `opnum1_in`.
- IDLE, `start_shift`: load `acc` = opnum1, `cnt` = shamt, and latch func and write-back info. Go to SHIFT. `valid_out` = 0 next cycle.
- SHIFT: each cycle, shift `acc` by one bit and decrement `cnt`.
  - SLL fills with 0. SRL fills with 0. SRA replicates bit 31.
  - When `cnt` = 1, this is the final shift: register the result, set `valid_out` = 1, and return to IDLE.
- `stall_out` = `start_shift` OR (state = SHIFT AND `cnt` ≠ 1). It is low in the final SHIFT cycle so that ID/EX advances on that same edge.
- Arithmetic:
  - ADD and SUB wrap modulo 2^32.
  - SLT is a signed compare and SLTU an unsigned compare; both return 1 or 0 in bit 0.
- Outputs:
  - `reg_we_out` = `valid_out` AND latched `reg_we` AND (address ≠ 0).
  - The address and data outputs hold their last value while `valid_out` = 0.
- `eval_en_in` = 0 in IDLE: `valid_out` = 0 and `reg_we_out` = 0 next cycle.
- `flush_in` = 1 (highest priority below reset): next state IDLE, `valid_out` = 0, `reg_we_out` = 0, no shift start. `stall_out` is low in that cycle.

## Timing
- Reset: state = IDLE, `cnt` = 0, `acc` = 0. All outputs are 0: `stall_out`, `valid_out`, `reg_we_out`, `reg_write_addr_out`, `reg_write_data_out`.
- Reset is asserted asynchronously. Release is sampled on the first rising `clk`.
- Reset mid-SHIFT abandons the operation with no write-back.
- Non-shift latency: 1 cycle from operands presented to `valid_out`. Throughput is 1 operation per cycle.
- Shift by n (1–31): presented at edge E0, `valid_out` high in the cycle after edge En, so latency is n+1 cycles. `stall_out` is high for n cycles, from the presentation cycle through the cycle before the final shift.
- Back-to-back: the instruction following a shift is seen in IDLE in the same cycle in which `valid_out` for the shift is high.
- Flush in the final SHIFT cycle suppresses that result.

## Test plan
- ADD 0xFFFF_FFFF + 0x0000_0002, rd = 5, we = 1 → next cycle `valid_out` = 1, data = 0x0000_0001, `reg_we_out` = 1, addr = 5.
- SRA opnum1 = 0x8000_0000, opnum2 = 3 → `stall_out` high for 3 cycles, `valid_out` on cycle 4 with data = 0xF000_0000. The next instruction, ADD 1+1, yields 2 the following cycle.
- SLL 0x1 by 31, then SLT −1 < 1, then SLTU 0xFFFF_FFFF < 1 → results 0x8000_0000, 1, 0, in order, with correct stall gaps.
- SUB 5 − 7 with rd = 0, we = 1 → data = 0xFFFF_FFFE, `valid_out` = 1, `reg_we_out` = 0.
- SRL by 10 with `flush_in` pulsed at cycle 4 → `stall_out` drops that cycle, no `valid_out`, and state returns to IDLE.
- `rst` asserted low mid-SRL by 20 → all outputs 0 immediately. After release, an ADD completes in 1 cycle.
